// File: rtl/mc14500_fetch_seq_if.sv
// mc14500_fetch_seq_if
//   Bus between the MC14500B program sequencer, its program ROM and the ICU.
//   rom_addr  : sequencer -> ROM, word address (AW bits)
//   rom_data  : ROM -> sequencer, combinational 8-bit word at rom_addr
//   instr_op  : sequencer -> ICU, registered opcode (word[7:4])
//   instr_io  : sequencer -> ICU, registered I/O/RAM select (word[3:0])
//   instr_vld : sequencer -> ICU, one-cycle strobe qualifying instr_op/io
//   jmp_flag  : ICU -> sequencer, JMP flag, meaningful while instr_vld=1
//   rtn_flag  : ICU -> sequencer, RTN flag, meaningful while instr_vld=1
//   flag0     : ICU -> sequencer, FLAG0; together with jmp_flag requests a call
//   modport master : sequencer side; modport slave : ROM/ICU side.
interface mc14500_fetch_seq_if #(
  parameter int unsigned AW = 7
);
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [3:0]    instr_op;
  logic [3:0]    instr_io;
  logic          instr_vld;
  logic          jmp_flag;
  logic          rtn_flag;
  logic          flag0;

  modport master (
    output rom_addr, instr_op, instr_io, instr_vld,
    input  rom_data, jmp_flag, rtn_flag, flag0
  );

  modport slave (
    input  rom_addr, instr_op, instr_io, instr_vld,
    output rom_data, jmp_flag, rtn_flag, flag0
  );
endinterface

// File: rtl/mc14500_fetch_seq.sv
// mc14500_fetch_seq
//   Program sequencer for an MC14500B system. Owns the PC, reads the program
//   ROM, hands each word to the ICU as opcode/IO-select for one cycle and then
//   performs jump, call or return according to the ICU flags.
//   Sequence: FETCH (latch word, PC+1) -> EXEC (strobe, sample flags)
//             -> FETCH, or -> TGT (load PC from target byte, optional push) -> FETCH.
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   run     : 1 = sequence, 0 = hold in FETCH
//   bus     : mc14500_fetch_seq_if.master (ROM address/data, ICU strobe/flags)
//   pc_o    : current PC (debug)
//   stk_err : sticky return-stack error (push on full / pop on empty), rst only
// Parameters
//   AW    : ROM address width (<= 8); PC wraps modulo 2**AW
//   DEPTH : return-stack entries, used only with the call stack enabled
// Configuration
//   FETCH_CALL_STACK_EN defined   : DEPTH-entry LIFO return stack.
//   FETCH_CALL_STACK_EN undefined : single link register; a call overwrites it,
//                                   a return reads it without clearing it.
module mc14500_fetch_seq #(
  parameter int unsigned AW    = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  mc14500_fetch_seq_if.master bus,
  output logic [AW-1:0]       pc_o,
  output logic                stk_err
);

  if (AW < 1 || AW > 8) begin : g_aw_chk
    $error("mc14500_fetch_seq: AW must be 1..8");
  end
  if (DEPTH < 1) begin : g_depth_chk
    $error("mc14500_fetch_seq: DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_TGT
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [3:0]    op, op_nxt;
  logic [3:0]    io, io_nxt;
  logic          is_call, call_nxt;
  logic          err;

  // Return-address storage handshake (stack or link register below).
  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] push_val;
  logic [AW-1:0] pop_val;
  logic          pop_ok;
  logic          err_set;

  assign bus.rom_addr  = pc;
  assign bus.instr_op  = op;
  assign bus.instr_io  = io;
  assign bus.instr_vld = (state == S_EXEC);
  assign pc_o          = pc;
  assign stk_err       = err;

  // In TGT the PC addresses the target byte, so the return point is the word after it.
  assign push_val = pc + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= '0;
      op      <= '0;
      io      <= '0;
      is_call <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      op      <= op_nxt;
      io      <= io_nxt;
      is_call <= call_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    op_nxt    = op;
    io_nxt    = io;
    call_nxt  = is_call;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (run) begin
          op_nxt    = bus.rom_data[7:4];
          io_nxt    = bus.rom_data[3:0];
          pc_nxt    = pc + 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        call_nxt  = 1'b0;
        state_nxt = S_FETCH;
        if (bus.jmp_flag) begin
          // JMP takes priority over RTN; PC already points at the target byte.
          call_nxt  = bus.flag0;
          state_nxt = S_TGT;
        end else if (bus.rtn_flag) begin
          do_pop = 1'b1;
          pc_nxt = pop_ok ? pop_val : '0;
        end
      end
      S_TGT: begin
        pc_nxt    = bus.rom_data[AW-1:0];
        do_push   = is_call;
        call_nxt  = 1'b0;
        state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

`ifdef FETCH_CALL_STACK_EN
  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  stk [DEPTH];
  logic [SPW-1:0] sp;
  logic           full;
  logic [IW-1:0]  top_idx;

  assign full    = (sp == SPW'(DEPTH));
  assign pop_ok  = (sp != '0);
  assign top_idx = IW'(sp - 1'b1);
  assign pop_val = pop_ok ? stk[top_idx] : '0;
  assign err_set = (do_push && full) || (do_pop && !pop_ok);

  // A full stack drops the push but the jump itself has already been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else if (do_push && !full) begin
      stk[IW'(sp)] <= push_val;
      sp           <= sp + 1'b1;
    end else if (do_pop && pop_ok) begin
      sp <= sp - 1'b1;
    end
  end
`else
  logic [AW-1:0] link;
  logic          link_vld;

  assign pop_ok  = link_vld;
  assign pop_val = link;
  assign err_set = do_pop && !link_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link     <= '0;
      link_vld <= 1'b0;
    end else if (do_push) begin
      link     <= push_val;
      link_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mc14500_fetch_seq.sv
module tb_mc14500_fetch_seq;
  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 4;
  localparam int          N     = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [AW-1:0] pc_o;
  logic          stk_err;

  mc14500_fetch_seq_if #(.AW(AW)) bus ();

  mc14500_fetch_seq #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .bus     (bus),
    .pc_o    (pc_o),
    .stk_err (stk_err)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [N];
  assign bus.rom_data = rom[bus.rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: address of the next word to be strobed, return storage, error.
  int m_pc;
  int m_stk[$];
  bit m_err;
  int m_link;
  bit m_link_vld;
  int m_lat;
  bit m_lat_vld;
  int m_last_cyc;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_pc = 0;
    m_stk.delete();
    m_err = 1'b0;
    m_link = 0;
    m_link_vld = 1'b0;
    m_lat_vld = 1'b0;
  endtask

  task automatic m_push(input int v);
`ifdef FETCH_CALL_STACK_EN
    if (m_stk.size() < DEPTH) m_stk.push_back(v);
    else m_err = 1'b1;
`else
    m_link = v;
    m_link_vld = 1'b1;
`endif
  endtask

  task automatic m_pop(output int v);
`ifdef FETCH_CALL_STACK_EN
    if (m_stk.size() > 0) v = m_stk.pop_back();
    else begin v = 0; m_err = 1'b1; end
`else
    if (m_link_vld) v = m_link;
    else begin v = 0; m_err = 1'b1; end
`endif
  endtask

  task automatic clear_flags();
    bus.jmp_flag = 1'b0;
    bus.rtn_flag = 1'b0;
    bus.flag0    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_flags();
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for the next strobe, checks it against the model, answers with the
  // given ICU flags and advances the model. Leaves time at the strobe negedge.
  task automatic step(input bit j, input bit r, input bit f);
    int waited = 0;
    int nxt;
    int v;
    @(negedge clk);
    clear_flags();
    while (!bus.instr_vld && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.instr_vld) begin
      check("strobe_timeout", bus.instr_vld, 1);
      m_lat_vld = 1'b0;
      return;
    end
    nxt = (m_pc + 1) % N;
    check("instr_op", bus.instr_op, rom[m_pc][7:4]);
    check("instr_io", bus.instr_io, rom[m_pc][3:0]);
    check("pc_o", pc_o, nxt);
    check("rom_addr", bus.rom_addr, nxt);
    check("stk_err", stk_err, m_err);
    if (m_lat_vld) check("latency", cyc - m_last_cyc, m_lat);
    m_last_cyc = cyc;
    m_lat_vld = 1'b1;
    bus.jmp_flag = j;
    bus.rtn_flag = r;
    bus.flag0    = f;
    if (j) begin
      if (f) m_push((nxt + 1) % N);
      m_pc = rom[nxt] % N;
      m_lat = 3;
    end else if (r) begin
      m_pop(v);
      m_pc = v;
      m_lat = 2;
    end else begin
      m_pc = nxt;
      m_lat = 2;
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    clear_flags();
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
    m_reset();

    // Reset state
    @(negedge clk);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_vld", bus.instr_vld, 0);
    check("rst_stk_err", stk_err, 0);
    check("rst_op", bus.instr_op, 0);

    // Straight-line 0x00..0x0F
    for (int i = 0; i < 16; i++) rom[i] = 8'(8'h10 + i);
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 0);
    check("straight_pc", pc_o, 16);

    // Plain jump from 0x05 to 0x40
    rom[5] = 8'hC0;
    rom[6] = 8'h40;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Call at 0x10 to 0x60, return to 0x12
    rom[0]    = 8'hC0;
    rom[1]    = 8'h10;
    rom[8'h10] = 8'hC8;
    rom[8'h11] = 8'h60;
    rom[8'h60] = 8'hD0;
    do_reset();
    step(1, 0, 0);
    step(1, 0, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    check("call_rtn_err", stk_err, 0);

    // Five nested calls, then returns down to an empty pop
    rom[0] = 8'hC8;
    rom[1] = 8'h00;
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Return with nothing saved, then reset while the strobe is up
    do_reset();
    step(0, 1, 0);
    step(0, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_rom_addr", bus.rom_addr, 0);
    check("rst_mid_vld", bus.instr_vld, 0);
    check("rst_mid_stk_err", stk_err, 0);
    check("rst_mid_pc", pc_o, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_flags();
    step(0, 0, 0);

    // Wrap through 0x7F, jump from the last address, then run gating
    rom[0] = 8'hC0;
    rom[1] = 8'h7C;
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clear_flags();
      check("run0_vld", bus.instr_vld, 0);
    end
    check("run0_pc", pc_o, m_pc);
    run = 1'b1;
    m_lat_vld = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);

    // Random program and random ICU answers
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(1) == 1);
    end

    @(negedge clk);
    clear_flags();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
